sensor_request_scheduler: RTL and testbench
===========================================

// Module: sensor_request_scheduler
// PURPOSE
//  Sequences host requests (UART command/address byte pair) onto the DHT11 read datapath.
//  Decodes command, enforces DHT11 min read spacing, launches reads, validates checksum.
//  Builds the 2-byte response (command, value) for the UART transmitter; runs continuous
//  temperature/humidity sensing until the host stops it.
// PARAMETERS
//  SENSOR_ADDR  8'h01        address this sensor answers to
//  MIN_GAP      50_000_000   min cycles between sensor_start pulses (1 s @ 50 MHz)
//  TIMEOUT      5_000_000    max cycles from sensor_start to sensor_done
//  LOOP_PERIOD  100_000_000  cycles between continuous-mode reads (must be >= MIN_GAP)
// PORTS
//  clock          in   1   system clock
//  reset          in   1   asynchronous, active-low reset
//  req_valid      in   1   request present
//  req_command    in   8   request command
//  req_address    in   8   request sensor address
//  req_ready      out  1   request accepted when req_valid & req_ready
//  sensor_start   out  1   one-cycle pulse: start one DHT11 transaction
//  sensor_done    in   1   one-cycle pulse: transaction finished, data valid
//  sensor_error   in   1   sampled with sensor_done: bus/protocol failure
//  sensor_data    in   40  {hum_int,hum_frac,temp_int,temp_frac,checksum}
//  resp_valid     out  1   response present; held until resp_ready
//  resp_ready     in   1   transmitter accepts response
//  resp_command   out  8   response command byte
//  resp_value     out  8   response value byte
//  loop_active    out  1   continuous mode running
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; gap counter saturated (first read immediate).
//  States: IDLE, DECODE, GAP, START, WAIT, RESP, LOOP_WAIT.
//  IDLE: req_ready=1. Accept -> latch cmd/addr -> DECODE. No request -> stay.
//  DECODE (1 cycle) -> RESP unless read needed:
//    addr!=SENSOR_ADDR -> 8'hEF/8'hEF.
//    0x00,0x01,0x02,0x03,0x04 -> GAP (read needed).
//    0x05,0x06 (no loop active) -> 8'hAA/8'hAA.
//    other -> 8'h45/8'h45.
//  GAP: wait until >= MIN_GAP cycles since last sensor_start -> START.
//  START: sensor_start=1 one cycle; gap counter cleared -> WAIT.
//  WAIT: sensor_done -> evaluate; TIMEOUT cycles w/o done -> error. done and timeout on the
//    same cycle: done wins.
//    Fail = sensor_error | timeout | (sum of 4 data bytes mod 256 != checksum) -> 8'h1F/8'h1F.
//    OK: 0x00 -> 07/07; 0x01,0x03 -> 09/temp_int; 0x02,0x04 -> 08/hum_int.
//    0x03/0x04 OK -> loop_active=1, loop kind latched.
//  RESP: resp_valid=1, command/value stable until resp_ready (same-cycle accept allowed).
//    On accept -> LOOP_WAIT if loop_active else IDLE.
//  LOOP_WAIT: req_ready=1; period counter runs; expiry -> GAP with latched loop command.
//    Request here:
//      matching stop (0x05 ends temp loop, 0x06 ends hum loop) -> loop_active=0, 0A/00 -> RESP.
//      other -> FF/FF -> RESP, loop continues.
//    Request and period expiry same cycle: request wins, counter restarts after its response.
//    Loop read failure: respond 1F/1F, loop continues.
//  Response latency: 2 cycles from accept to resp_valid for non-read commands.
//  Counters saturate, never wrap. req_ready=0 outside IDLE/LOOP_WAIT.
// TESTING
//  1. cmd 01, addr 01, data {37,00,19,00,56} -> one sensor_start; resp 09/19; back to IDLE.
//  2. cmd 02, checksum 8'h00 (bad) -> resp 1F/1F; sensor_error=1 -> resp 1F/1F.
//  3. cmd 00, addr 02 -> resp EF/EF, no sensor_start; cmd 7E -> resp 45/45.
//  4. cmd 03 -> resp 09/xx, then each LOOP_PERIOD another resp; cmd 01 in loop -> FF/FF;
//     cmd 05 -> 0A/00, loop_active=0.
//  5. Back-to-back cmd 01 -> second sensor_start exactly MIN_GAP cycles after first;
//     no sensor_done -> 1F/1F after TIMEOUT.
//  6. resp_ready low 10 cycles -> outputs stable; reset low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/sensor_request_scheduler.sv
// Host request scheduler for a DHT11 read datapath: decodes command/address pairs,
// paces sensor transactions, validates the returned checksum and builds the
// two-byte response. Also runs periodic temperature/humidity reads until stopped.
module sensor_request_scheduler #(
    parameter logic [7:0]  SENSOR_ADDR = 8'h01,
    parameter int unsigned MIN_GAP     = 50_000_000,
    parameter int unsigned TIMEOUT     = 5_000_000,
    parameter int unsigned LOOP_PERIOD = 100_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [7:0]  req_command,
    input  logic [7:0]  req_address,
    output logic        req_ready,
    output logic        sensor_start,
    input  logic        sensor_done,
    input  logic        sensor_error,
    input  logic [39:0] sensor_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_command,
    output logic [7:0]  resp_value,
    output logic        loop_active
);

    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned PER_W = $clog2(LOOP_PERIOD + 1);

    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [PER_W-1:0] PER_MAX  = PER_W'(LOOP_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(LOOP_PERIOD - 1);

    localparam logic [7:0] CMD_READ_ALL  = 8'h00;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_HUM       = 8'h02;
    localparam logic [7:0] CMD_LOOP_TEMP = 8'h03;
    localparam logic [7:0] CMD_LOOP_HUM  = 8'h04;
    localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
    localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_GAP,
        S_START,
        S_WAIT,
        S_RESP,
        S_LOOP_WAIT
    } state_t;

    state_t             state_q;
    logic               req_ready_q;
    logic               sensor_start_q;
    logic               resp_valid_q;
    logic [7:0]         resp_command_q;
    logic [7:0]         resp_value_q;
    logic               loop_active_q;
    logic [7:0]         loop_cmd_q;
    logic [7:0]         cmd_q;
    logic [7:0]         addr_q;
    logic [GAP_W-1:0]   gap_q;
    logic [TO_W-1:0]    to_q;
    logic [PER_W-1:0]   per_q;

    logic [7:0] data_sum_c;
    logic       read_ok_c;
    logic       req_accept_c;
    logic       gap_met_c;
    logic       launch_c;
    logic       timeout_c;
    logic       period_done_c;
    logic       stop_match_c;
    logic       dec_read_c;
    logic       dec_stop_c;
    logic [7:0] dec_cmd_c;
    logic [7:0] dec_val_c;
    logic [7:0] read_cmd_c;
    logic [7:0] read_val_c;

    assign data_sum_c    = sensor_data[39:32] + sensor_data[31:24]
                         + sensor_data[23:16] + sensor_data[15:8];
    assign read_ok_c     = !sensor_error && (data_sum_c == sensor_data[7:0]);
    assign req_accept_c  = req_valid && req_ready_q;
    assign gap_met_c     = (gap_q >= GAP_LAST);
    assign launch_c      = (state_q == S_GAP) && gap_met_c;
    assign timeout_c     = (to_q >= TO_MAX);
    assign period_done_c = (per_q >= PER_LAST);
    assign stop_match_c  = (addr_q == SENSOR_ADDR) &&
                           (((cmd_q == CMD_STOP_TEMP) && (loop_cmd_q == CMD_LOOP_TEMP)) ||
                            ((cmd_q == CMD_STOP_HUM)  && (loop_cmd_q == CMD_LOOP_HUM)));

    assign req_ready    = req_ready_q;
    assign sensor_start = sensor_start_q;
    assign resp_valid   = resp_valid_q;
    assign resp_command = resp_command_q;
    assign resp_value   = resp_value_q;
    assign loop_active  = loop_active_q;

    // Command decode: immediate response bytes, or a request for a sensor read.
    always_comb begin
        dec_read_c = 1'b0;
        dec_stop_c = 1'b0;
        dec_cmd_c  = 8'h45;
        dec_val_c  = 8'h45;
        if (loop_active_q) begin
            if (stop_match_c) begin
                dec_stop_c = 1'b1;
                dec_cmd_c  = 8'h0A;
                dec_val_c  = 8'h00;
            end else begin
                dec_cmd_c = 8'hFF;
                dec_val_c = 8'hFF;
            end
        end else if (addr_q != SENSOR_ADDR) begin
            dec_cmd_c = 8'hEF;
            dec_val_c = 8'hEF;
        end else if (cmd_q <= CMD_LOOP_HUM) begin
            dec_read_c = 1'b1;
        end else if ((cmd_q == CMD_STOP_TEMP) || (cmd_q == CMD_STOP_HUM)) begin
            dec_cmd_c = 8'hAA;
            dec_val_c = 8'hAA;
        end
    end

    // Response bytes for a completed sensor transaction.
    always_comb begin
        read_cmd_c = 8'h1F;
        read_val_c = 8'h1F;
        if (read_ok_c) begin
            case (cmd_q)
                CMD_READ_ALL: begin
                    read_cmd_c = 8'h07;
                    read_val_c = 8'h07;
                end
                CMD_TEMP, CMD_LOOP_TEMP: begin
                    read_cmd_c = 8'h09;
                    read_val_c = sensor_data[23:16];
                end
                CMD_HUM, CMD_LOOP_HUM: begin
                    read_cmd_c = 8'h08;
                    read_val_c = sensor_data[39:32];
                end
                default: begin
                    read_cmd_c = 8'h1F;
                    read_val_c = 8'h1F;
                end
            endcase
        end
    end

    // Cycles since the last sensor_start; starts saturated so the first read is immediate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap_q <= GAP_MAX;
        end else if (launch_c) begin
            gap_q <= '0;
        end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + GAP_W'(1);
        end
    end

    // Cycles since the current transaction was launched, for the done timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_q <= '0;
        end else if (launch_c) begin
            to_q <= '0;
        end else if (to_q != TO_MAX) begin
            to_q <= to_q + TO_W'(1);
        end
    end

    // Continuous-mode period counter; restarts on every entry into LOOP_WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per_q <= '0;
        end else if (state_q != S_LOOP_WAIT) begin
            per_q <= '0;
        end else if (per_q != PER_MAX) begin
            per_q <= per_q + PER_W'(1);
        end
    end

    // Main sequencer with registered handshake and response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            req_ready_q    <= 1'b0;
            sensor_start_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_command_q <= 8'h00;
            resp_value_q   <= 8'h00;
            loop_active_q  <= 1'b0;
            loop_cmd_q     <= 8'h00;
            cmd_q          <= 8'h00;
            addr_q         <= 8'h00;
        end else begin
            sensor_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_accept_c) begin
                        cmd_q       <= req_command;
                        addr_q      <= req_address;
                        req_ready_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_read_c) begin
                        state_q <= S_GAP;
                    end else begin
                        resp_valid_q   <= 1'b1;
                        resp_command_q <= dec_cmd_c;
                        resp_value_q   <= dec_val_c;
                        state_q        <= S_RESP;
                        if (dec_stop_c) begin
                            loop_active_q <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_met_c) begin
                        sensor_start_q <= 1'b1;
                        state_q        <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (sensor_done) begin
                        resp_valid_q   <= 1'b1;
                        resp_command_q <= read_cmd_c;
                        resp_value_q   <= read_val_c;
                        state_q        <= S_RESP;
                        if (read_ok_c && ((cmd_q == CMD_LOOP_TEMP) || (cmd_q == CMD_LOOP_HUM))) begin
                            loop_active_q <= 1'b1;
                            loop_cmd_q    <= cmd_q;
                        end
                    end else if (timeout_c) begin
                        resp_valid_q   <= 1'b1;
                        resp_command_q <= 8'h1F;
                        resp_value_q   <= 8'h1F;
                        state_q        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= loop_active_q ? S_LOOP_WAIT : S_IDLE;
                    end
                end
                S_LOOP_WAIT: begin
                    if (req_accept_c) begin
                        cmd_q       <= req_command;
                        addr_q      <= req_address;
                        req_ready_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end else if (period_done_c) begin
                        cmd_q       <= loop_cmd_q;
                        addr_q      <= SENSOR_ADDR;
                        req_ready_q <= 1'b0;
                        state_q     <= S_GAP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Self-checking bench for sensor_request_scheduler: behavioural sensor responder,
// rule-level response model, directed scenarios plus randomized requests.
module tb_sensor_request_scheduler;

    localparam int unsigned MIN_GAP     = 40;
    localparam int unsigned TIMEOUT     = 30;
    localparam int unsigned LOOP_PERIOD = 60;
    localparam int          BOUND       = 3 * (MIN_GAP + TIMEOUT + LOOP_PERIOD);

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_command = 8'h00;
    logic [7:0]  req_address = 8'h00;
    logic        req_ready;
    logic        sensor_start;
    logic        sensor_done = 1'b0;
    logic        sensor_error = 1'b0;
    logic [39:0] sensor_data = 40'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_command;
    logic [7:0]  resp_value;
    logic        loop_active;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_starts = 0;
    int start_cyc[$];
    int last_accept_cyc = 0;
    int sens_delay = 5;
    bit sens_silent = 1'b0;
    bit m_loop = 1'b0;
    logic [7:0] m_loop_cmd = 8'h00;

    sensor_request_scheduler #(
        .SENSOR_ADDR (8'h01),
        .MIN_GAP     (MIN_GAP),
        .TIMEOUT     (TIMEOUT),
        .LOOP_PERIOD (LOOP_PERIOD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_command  (req_command),
        .req_address  (req_address),
        .req_ready    (req_ready),
        .sensor_start (sensor_start),
        .sensor_done  (sensor_done),
        .sensor_error (sensor_error),
        .sensor_data  (sensor_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_command (resp_command),
        .resp_value   (resp_value),
        .loop_active  (loop_active)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Sensor responder: answers each start pulse with a done pulse sens_delay cycles later.
    initial begin
        int done_cnt;
        done_cnt = 0;
        forever begin
            @(negedge clock);
            sensor_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) sensor_done = 1'b1;
            end
            if (sensor_start === 1'b1) begin
                n_starts++;
                start_cyc.push_back(cyc);
                done_cnt = sens_silent ? 0 : sens_delay;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] pack(input int hi, input int hf, input int ti, input int tf,
                                         input bit good);
        int s;
        s = (hi + hf + ti + tf) % 256;
        if (!good) s = (s + 1 + int'($urandom_range(0, 254))) % 256;
        return {8'(hi), 8'(hf), 8'(ti), 8'(tf), 8'(s)};
    endfunction

    // Outcome of one sensor read under the current responder settings.
    task automatic model_read(input logic [7:0] cmd, output logic [15:0] r);
        int  s;
        bit  ok;
        s  = (int'(sensor_data[39:32]) + int'(sensor_data[31:24]) +
              int'(sensor_data[23:16]) + int'(sensor_data[15:8])) % 256;
        ok = !sensor_error && !sens_silent && (sens_delay <= int'(TIMEOUT)) &&
             (s == int'(sensor_data[7:0]));
        if (!ok) begin
            r = 16'h1F1F;
        end else begin
            if (cmd == 8'h03 || cmd == 8'h04) begin
                m_loop     = 1'b1;
                m_loop_cmd = cmd;
            end
            if (cmd == 8'h00)                     r = 16'h0707;
            else if (cmd == 8'h01 || cmd == 8'h03) r = {8'h09, sensor_data[23:16]};
            else                                   r = {8'h08, sensor_data[39:32]};
        end
    endtask

    task automatic model_req(input logic [7:0] cmd, input logic [7:0] addr,
                             output logic [15:0] r, output bit rd);
        rd = 1'b0;
        if (m_loop) begin
            if (addr == 8'h01 && ((cmd == 8'h05 && m_loop_cmd == 8'h03) ||
                                  (cmd == 8'h06 && m_loop_cmd == 8'h04))) begin
                m_loop = 1'b0;
                r = 16'h0A00;
            end else begin
                r = 16'hFFFF;
            end
        end else if (addr != 8'h01) begin
            r = 16'hEFEF;
        end else if (cmd <= 8'h04) begin
            rd = 1'b1;
            model_read(cmd, r);
        end else if (cmd == 8'h05 || cmd == 8'h06) begin
            r = 16'hAAAA;
        end else begin
            r = 16'h4545;
        end
    endtask

    task automatic accept_resp(input string tag);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check_eq({tag, "_clr"}, 64'(resp_valid), 64'(0));
    endtask

    task automatic do_req(input logic [7:0] cmd, input logic [7:0] addr, input int hold,
                          input string tag);
        logic [15:0] exp;
        bit rd;
        int n0;
        int t;
        model_req(cmd, addr, exp, rd);
        n0 = n_starts;
        t = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && t < BOUND) begin
            @(negedge clock);
            t++;
        end
        if (req_ready !== 1'b1) begin
            check_eq({tag, "_ready"}, 64'(req_ready), 64'(1));
            return;
        end
        req_valid   = 1'b1;
        req_command = cmd;
        req_address = addr;
        @(negedge clock);
        req_valid = 1'b0;
        last_accept_cyc = cyc;
        if (!rd) begin
            check_eq({tag, "_lat1"}, 64'(resp_valid), 64'(0));
            @(negedge clock);
        end else begin
            t = 0;
            while (resp_valid !== 1'b1 && t < BOUND) begin
                @(negedge clock);
                t++;
            end
        end
        check_eq({tag, "_resp"}, 64'({resp_valid, resp_command, resp_value}), 64'({1'b1, exp}));
        check_eq({tag, "_starts"}, 64'(n_starts - n0), 64'(rd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq({tag, "_hold"}, 64'({resp_valid, resp_command, resp_value}), 64'({1'b1, exp}));
        end
        accept_resp(tag);
    endtask

    task automatic wait_resp(input string tag);
        logic [15:0] exp;
        int n0;
        int t;
        n0 = n_starts;
        model_read(m_loop_cmd, exp);
        t = 0;
        while (resp_valid !== 1'b1 && t < BOUND) begin
            @(negedge clock);
            t++;
        end
        check_eq({tag, "_resp"}, 64'({resp_valid, resp_command, resp_value}), 64'({1'b1, exp}));
        check_eq({tag, "_starts"}, 64'(n_starts - n0), 64'(1));
        accept_resp(tag);
    endtask

    initial begin
        int i0;
        int t;
        sensor_data = pack(37, 0, 19, 0, 1'b1);

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_outputs", 64'({req_ready, sensor_start, resp_valid, resp_command,
                                      resp_value, loop_active}), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_ready", 64'(req_ready), 64'(1));

        // Basic temperature read, first read launches without gap wait
        do_req(8'h01, 8'h01, 0, "t1_temp");
        check_eq("t1_immediate", 64'((start_cyc.size() > 0) &&
                                     (start_cyc[$] - last_accept_cyc <= 3)), 64'(1));
        check_eq("t1_idle", 64'({req_ready, loop_active}), 64'(2'b10));

        // Bad checksum, sensor error, then good humidity
        sensor_data = pack(45, 3, 22, 1, 1'b0);
        do_req(8'h02, 8'h01, 0, "t2_badsum");
        sensor_data  = pack(45, 3, 22, 1, 1'b1);
        sensor_error = 1'b1;
        do_req(8'h02, 8'h01, 0, "t2_err");
        sensor_error = 1'b0;
        do_req(8'h02, 8'h01, 0, "t2_hum");

        // Immediate-response commands
        do_req(8'h00, 8'h02, 0, "t3_addr");
        do_req(8'h7E, 8'h01, 0, "t3_unknown");
        do_req(8'h05, 8'h01, 0, "t3_stop_idle");
        do_req(8'h00, 8'h01, 0, "t3_all");

        // Back-to-back reads obey exact minimum spacing; timeout boundaries
        sens_delay = 3;
        i0 = start_cyc.size();
        do_req(8'h01, 8'h01, 0, "t5_first");
        do_req(8'h01, 8'h01, 0, "t5_second");
        check_eq("t5_gap", 64'(start_cyc[i0 + 1] - start_cyc[i0]), 64'(MIN_GAP));
        sens_delay = int'(TIMEOUT);
        do_req(8'h00, 8'h01, 0, "t5_done_at_limit");
        sens_delay = int'(TIMEOUT) + 1;
        do_req(8'h00, 8'h01, 0, "t5_done_late");
        sens_delay  = 4;
        sens_silent = 1'b1;
        do_req(8'h01, 8'h01, 0, "t5_silent");
        sens_silent = 1'b0;

        // Response held stable while transmitter stalls
        do_req(8'h01, 8'h01, 10, "t6_hold");

        // Temperature loop: periodic reads, loop failure, foreign request, stop
        sensor_data = pack(50, 0, 21, 5, 1'b1);
        do_req(8'h03, 8'h01, 0, "t4_start");
        check_eq("t4_active", 64'(loop_active), 64'(1));
        sensor_data = pack(51, 0, 23, 0, 1'b1);
        wait_resp("t4_period1");
        sensor_error = 1'b1;
        wait_resp("t4_fail");
        check_eq("t4_active_after_fail", 64'(loop_active), 64'(1));
        sensor_error = 1'b0;
        sensor_data  = pack(52, 0, 24, 2, 1'b1);
        wait_resp("t4_period3");
        do_req(8'h01, 8'h01, 0, "t4_foreign");
        do_req(8'h05, 8'h01, 0, "t4_stop");
        check_eq("t4_inactive", 64'(loop_active), 64'(0));
        i0 = n_starts;
        repeat (LOOP_PERIOD + MIN_GAP + 20) @(negedge clock);
        check_eq("t4_no_more_reads", 64'(n_starts - i0), 64'(0));

        // Humidity loop: wrong stop rejected, matching stop accepted
        do_req(8'h04, 8'h01, 0, "t4h_start");
        do_req(8'h05, 8'h01, 0, "t4h_wrong_stop");
        do_req(8'h06, 8'h01, 0, "t4h_stop");
        check_eq("t4h_inactive", 64'(loop_active), 64'(0));

        // Randomized requests against the model
        for (int i = 0; i < 12; i++) begin
            logic [7:0] cmd;
            logic [7:0] addr;
            int k;
            k = int'($urandom_range(0, 7));
            case (k)
                0: cmd = 8'h00;
                1: cmd = 8'h01;
                2: cmd = 8'h02;
                3: cmd = 8'h05;
                4: cmd = 8'h06;
                5: cmd = 8'h7E;
                default: cmd = 8'($urandom_range(5, 255));
            endcase
            addr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h01;
            sensor_data = pack(int'($urandom_range(0, 99)), int'($urandom_range(0, 9)),
                               int'($urandom_range(0, 50)), int'($urandom_range(0, 9)),
                               $urandom_range(0, 3) != 0);
            sensor_error = ($urandom_range(0, 6) == 0);
            sens_silent  = ($urandom_range(0, 9) == 0);
            sens_delay   = int'($urandom_range(1, TIMEOUT + 2));
            do_req(cmd, addr, int'($urandom_range(0, 3)), "rand");
        end
        sensor_error = 1'b0;
        sens_silent  = 1'b0;
        sens_delay   = 4;

        // Every pair of launches respects the minimum spacing
        for (int i = 1; i < start_cyc.size(); i++) begin
            check_eq("spacing", 64'(start_cyc[i] - start_cyc[i - 1] >= int'(MIN_GAP)), 64'(1));
        end

        // Asynchronous reset in the middle of a loop read
        sensor_data = pack(40, 0, 20, 0, 1'b1);
        do_req(8'h03, 8'h01, 0, "t6_loop");
        sens_silent = 1'b1;
        i0 = n_starts;
        t = 0;
        while (n_starts == i0 && t < BOUND) begin
            @(negedge clock);
            t++;
        end
        repeat (3) @(negedge clock);
        check_eq("t6_pre_reset", 64'({loop_active, resp_command}), 64'({1'b1, 8'h09}));
        #2 reset = 1'b0;
        #1;
        check_eq("t6_async_rst", 64'({req_ready, sensor_start, resp_valid, resp_command,
                                       resp_value, loop_active}), 64'(0));
        m_loop = 1'b0;
        start_cyc.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        sens_silent = 1'b0;
        do_req(8'h00, 8'h01, 0, "t6_after_rst");
        check_eq("t6_immediate", 64'((start_cyc.size() > 0) &&
                                     (start_cyc[$] - last_accept_cyc <= 3)), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
